dff_bank_arbiter: RTL
=====================

// Module: dff_bank_arbiter
// PURPOSE
//   Round-robin write arbiter for a shared WIDTH-bit D flip-flop bank (q register).
//   NREQ requesters compete to load the bank. The winner's data is captured, then
//   held stable for HOLD_CYC cycles before the next arbitration.
//   Sits between requester logic and any consumer of the registered value.
// PARAMETERS
//   NREQ      4  number of requesters (2..16)
//   WIDTH     8  bank width in bits
//   HOLD_CYC  3  cycles q is held after a load, before re-arbitration (0 = no hold)
// PORTS
//   clk      in   1           system clock, rising edge
//   reset    in   1           synchronous, active-high reset
//   req      in   NREQ        per-requester write request, level-sensitive
//   data_in  in   NREQ*WIDTH  requester i data at [i*WIDTH +: WIDTH]
//   gnt      out  NREQ        one-hot grant, registered, high for exactly 1 cycle
//   q        out  WIDTH       shared register bank contents
//   q_valid  out  1           bank has been loaded at least once since reset
//   owner    out  clog2(NREQ) index of the last granted requester
//   busy     out  1           state != IDLE
// BEHAVIOUR
//   Reset (sync, active-high, overrides every other event):
//   - state=IDLE; q=0; q_valid=0; gnt=0; owner=0; busy=0; rr_ptr=0; hold_cnt=0.
//   IDLE:
//   - If req!=0, winner = first set req bit scanning cyclically from rr_ptr upward.
//   - Next edge: gnt<=onehot(winner); owner<=winner; state<=LOAD.
//   - If req==0, stay in IDLE.
//   LOAD (gnt high during this cycle only):
//   - Edge: q<=data_in[owner]; q_valid<=1; gnt<=0; rr_ptr<=(owner+1) mod NREQ.
//   - Next state: HOLD with hold_cnt<=HOLD_CYC-1; IDLE if HOLD_CYC==0.
//   - The write is committed once granted: q still loads if req[owner] drops
//     during LOAD.
//   HOLD:
//   - req is ignored. hold_cnt decrements each cycle.
//   - At hold_cnt==0, next state = IDLE.
//   Latency and timing:
//   - Request sampled at edge E0 -> gnt high E0..E1 -> q valid after E1.
//   - Grant spacing under continuous requests = HOLD_CYC+2 cycles.
//   Counters and widths:
//   - hold_cnt width = max(1, clog2(HOLD_CYC+1)).
//   - rr_ptr wraps NREQ-1 -> 0.
//   Outputs:
//   - q changes only on the LOAD edge or on reset.
//   - q_valid never clears except on reset.
// CONFIGURATION
//   DFF_ARB_LOCK_EN defined:
//   - Adds input lock [NREQ] (per-requester).
//   - In HOLD at hold_cnt==0: if lock[owner]==1 and req[owner]==1, go to LOAD with
//     the same owner (gnt re-asserted, no IDLE cycle, rr_ptr unchanged).
//     Otherwise go to IDLE.
//   - Lock is sampled only at that terminal HOLD cycle.
//   DFF_ARB_LOCK_EN undefined:
//   - No lock port; HOLD always returns to IDLE.
// TESTING (NREQ=4, WIDTH=8, HOLD_CYC=3)
//   1. Hold reset=1 for 2 cycles with req=4'b1111 -> q=8'h00, q_valid=0, gnt=0,
//      busy=0, owner=0.
//   2. req=4'b0100, slice2=8'hA5 -> gnt=4'b0100 for 1 cycle; q=8'hA5 and q_valid=1
//      after the next edge; busy high for 4 cycles.
//   3. req=4'b1111 held, slice i=8'h10+i -> q sequence 10,11,12,13,10; grants
//      exactly 5 cycles apart.
//   4. Assert reset during HOLD after loading 8'h3C -> next cycle: IDLE, q=0,
//      q_valid=0, rr_ptr=0; a following req=4'b1010 grants requester 1.
//   5. rr_ptr=3 and req=4'b1001 held -> grant order 3, 0, 3 (wrap-around).
//   6. DFF_ARB_LOCK_EN defined, owner=1, lock=4'b0010, req=4'b0011 -> requester 1
//      is re-granted immediately after HOLD with no IDLE cycle.
//      Macro undefined, same stimulus -> next grant goes to requester 0.

Source files
------------

// File: rtl/dff_bank_arbiter.sv
// Round-robin write arbiter for a shared WIDTH-bit register bank (q).
// Optional macro DFF_ARB_LOCK_EN adds a per-requester lock input.
//
// Ports:
//   clk     : rising-edge clock
//   reset   : synchronous active-high reset
//   req     : per-requester write request (level)
//   data_in : requester i data at [i*WIDTH +: WIDTH]
//   lock    : (DFF_ARB_LOCK_EN only) keep ownership across holds
//   gnt     : one-hot registered grant, one cycle wide
//   q       : shared bank contents
//   q_valid : bank loaded at least once since reset
//   owner   : index of the last granted requester
//   busy    : arbiter not idle
module dff_bank_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int HOLD_CYC = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    data_in,
`ifdef DFF_ARB_LOCK_EN
  input  logic [NREQ-1:0]          lock,
`endif
  output logic [NREQ-1:0]          gnt,
  output logic [WIDTH-1:0]         q,
  output logic                     q_valid,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     busy
);

  localparam int OW  = $clog2(NREQ);
  localparam int HCW = (HOLD_CYC < 1) ? 1 : $clog2(HOLD_CYC + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    HOLD
  } state_t;

  state_t          state;
  logic [OW-1:0]   rr_ptr;
  logic [OW-1:0]   win;
  logic [OW-1:0]   nxt_ptr;
  logic [OW:0]     idx;
  logic [HCW-1:0]  hold_cnt;
  logic            any;
  logic            relock;
  logic [WIDTH-1:0] slice [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign slice[i] = data_in[i*WIDTH +: WIDTH];
  end

  // Cyclic priority scan starting at rr_ptr; idx carries one
  // extra bit so the wrap works for non power-of-two NREQ.
  always_comb begin
    win = '0;
    any = 1'b0;
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, rr_ptr} + (OW+1)'(i);
      if (idx >= (OW+1)'(NREQ))
        idx = idx - (OW+1)'(NREQ);
      if (!any && req[idx[OW-1:0]]) begin
        any = 1'b1;
        win = idx[OW-1:0];
      end
    end
  end

  assign nxt_ptr = (owner == OW'(NREQ-1)) ? '0
                 : owner + 1'b1;

`ifdef DFF_ARB_LOCK_EN
  assign relock = lock[owner] & req[owner];
`else
  assign relock = 1'b0;
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      q        <= '0;
      q_valid  <= 1'b0;
      gnt      <= '0;
      owner    <= '0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            gnt   <= NREQ'(1) << win;
            owner <= win;
            state <= LOAD;
          end
        end
        LOAD: begin
          // committed once granted: req is not rechecked
          q       <= slice[owner];
          q_valid <= 1'b1;
          gnt     <= '0;
          rr_ptr  <= nxt_ptr;
          if (HOLD_CYC == 0) begin
            state <= IDLE;
          end else begin
            state    <= HOLD;
            hold_cnt <= HCW'(HOLD_CYC - 1);
          end
        end
        HOLD: begin
          if (hold_cnt == '0) begin
            if (relock) begin
              gnt   <= NREQ'(1) << owner;
              state <= LOAD;
            end else begin
              state <= IDLE;
            end
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
